input_debouncer: RTL and testbench

- Synchronizes and debounces the board's raw pushbutton and slide-switch inputs (key[1:0], sw[3:0]) into glitch-free logical levels.
- Emits one-cycle press and release pulses for each channel.
- Sits directly upstream of the Main top-level logic, which consumes the clean levels and pulses instead of the raw pins.
- Runs on clock_50.

---
 rtl/input_pkg.sv | 30 +++
 rtl/debounce_channel.sv | 80 ++++++++
 rtl/input_debouncer.sv | 32 +++
 tb/tb_input_debouncer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
// Shared board-level constants for the pushbutton/switch debouncer: timing,
// input polarity and the channel index map.
package input_pkg;

  localparam int CLOCK_HZ    = 50_000_000;
  localparam int DEBOUNCE_MS = 10;

  function automatic int cycles_for_ms(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int DEFAULT_STABLE_CYCLES = cycles_for_ms(CLOCK_HZ, DEBOUNCE_MS);

  localparam int NUM_KEYS     = 2;
  localparam int NUM_SWITCHES = 4;
  localparam int NUM_CHANNELS = NUM_KEYS + NUM_SWITCHES;

  // DE0-Nano-SoC keys pull low when pressed; slide switches read high when on.
  localparam logic [NUM_KEYS-1:0]     KEY_INVERT     = 2'b11;
  localparam logic [NUM_SWITCHES-1:0] SW_INVERT      = 4'b0000;
  localparam logic [NUM_CHANNELS-1:0] DEFAULT_INVERT = {SW_INVERT, KEY_INVERT};

  localparam int KEY0 = 0;
  localparam int KEY1 = 1;
  localparam int SW0  = 2;
  localparam int SW1  = 3;
  localparam int SW2  = 4;
  localparam int SW3  = 5;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: two-flop synchronizer, stability counter, clean level
// and registered one-cycle rise/fall pulses.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   STABLE   | counter = 0, synchronized sample agrees with level
//   SETTLING | counter > 0, sample has disagreed for counter cycles in a row
module debounce_channel
  import input_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic INVERT_BIT    = 1'b0
) (
  input  logic clock_50,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_SETTLING = 1'b1;

  logic          sync1;
  logic          sync2;
  logic          sample;
  logic [CW-1:0] counter;
  logic [0:0]    state;

  assign sample = sync2 ^ INVERT_BIT;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      // Synchronizer preloads the inactive pin level so it reads as logical 0.
      sync1   <= INVERT_BIT;
      sync2   <= INVERT_BIT;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      counter <= '0;
      state   <= ST_STABLE;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      case (state)
        ST_STABLE: begin
          if (sample != level) begin
            counter <= CW'(1);
            state   <= ST_SETTLING;
          end
        end
        ST_SETTLING: begin
          if (sample == level) begin
            counter <= '0;
            state   <= ST_STABLE;
          end else if (counter == TERM) begin
            level   <= sample;
            rise    <= sample;
            fall    <= ~sample;
            counter <= '0;
            state   <= ST_STABLE;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        default: begin
          counter <= '0;
          state   <= ST_STABLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Debounces the raw key/switch pins into clean levels and edge pulses for the
// main top-level logic; one independent debounce_channel per pin.
module input_debouncer
  import input_pkg::*;
#(
  parameter int               WIDTH         = NUM_CHANNELS,
  parameter int               STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic [WIDTH-1:0] INVERT        = DEFAULT_INVERT
) (
  input  logic             clock_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .INVERT_BIT    (INVERT[i])
    ) u_ch (
      .clock_50 (clock_50),
      .reset    (reset),
      .raw_in   (raw_in[i]),
      .level    (level[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed test-plan scenarios plus random pin
// activity, compared every cycle against a sample-history reference model.
module tb_input_debouncer;

  localparam int N = 4;

  logic       clock_50 = 1'b0;
  logic       reset_a, reset_b;
  logic [1:0] raw_a, raw_b;
  logic [1:0] level_a, rise_a, fall_a;
  logic [1:0] level_b, rise_b, fall_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clock_50 = ~clock_50;

  // Active-low channels (keys)
  input_debouncer #(.WIDTH(2), .STABLE_CYCLES(N), .INVERT(2'b11)) u_dut_a (
    .clock_50 (clock_50),
    .reset    (reset_a),
    .raw_in   (raw_a),
    .level    (level_a),
    .rise     (rise_a),
    .fall     (fall_a)
  );

  // Active-high channels
  input_debouncer #(.WIDTH(2), .STABLE_CYCLES(N), .INVERT(2'b00)) u_dut_b (
    .clock_50 (clock_50),
    .reset    (reset_b),
    .raw_in   (raw_b),
    .level    (level_b),
    .rise     (rise_b),
    .fall     (fall_b)
  );

  // Model index k = dut*2 + channel; history holds the last N logical samples.
  logic m_p1[4], m_p2[4], m_lvl[4], m_rise[4], m_fall[4];
  logic m_hist[4][$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int d, input logic [1:0] raw, input logic rst,
                            input logic [1:0] inv);
    for (int c = 0; c < 2; c++) begin
      int   k;
      logic s;
      logic all_diff;
      k = d * 2 + c;
      if (rst) begin
        m_p1[k] = 1'b0;
        m_p2[k] = 1'b0;
        m_lvl[k] = 1'b0;
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
        m_hist[k].delete();
      end else begin
        s = m_p2[k];
        m_p2[k] = m_p1[k];
        m_p1[k] = raw[c] ^ inv[c];
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
        m_hist[k].push_back(s);
        if (m_hist[k].size() > N) void'(m_hist[k].pop_front());
        all_diff = (m_hist[k].size() == N);
        for (int j = 0; j < m_hist[k].size(); j++)
          if (m_hist[k][j] == m_lvl[k]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[k] = s;
          m_rise[k] = s;
          m_fall[k] = !s;
          m_hist[k].delete();
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock_50);
    model_edge(0, raw_a, reset_a, 2'b11);
    model_edge(1, raw_b, reset_b, 2'b00);
    @(negedge clock_50);
    check("model_level_a", level_a, {m_lvl[1], m_lvl[0]});
    check("model_rise_a", rise_a, {m_rise[1], m_rise[0]});
    check("model_fall_a", fall_a, {m_fall[1], m_fall[0]});
    check("model_level_b", level_b, {m_lvl[3], m_lvl[2]});
    check("model_rise_b", rise_b, {m_rise[3], m_rise[2]});
    check("model_fall_b", fall_b, {m_fall[3], m_fall[2]});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int hold_a;
    int hold_b;
    hold_a = 0;
    hold_b = 0;

    reset_a = 1'b1; reset_b = 1'b1; raw_a = 2'b11; raw_b = 2'b00;
    ticks(3);
    check("reset_level", level_a, 2'b00);
    check("reset_rise", rise_a, 2'b00);
    check("reset_fall", fall_a, 2'b00);
    reset_a = 1'b0; reset_b = 1'b0;
    ticks(6);
    check("idle_level", level_a, 2'b00);

    // Clean press on channel 0 (active-low): first capture is edge 0
    raw_a = 2'b10;
    ticks(5);
    check("press_early", level_a, 2'b00);
    tick();
    check("press_level", level_a, 2'b01);
    check("press_rise", rise_a, 2'b01);
    check("press_fall", fall_a, 2'b00);
    tick();
    check("press_pulse_end", rise_a, 2'b00);

    raw_a = 2'b11;
    ticks(5);
    tick();
    check("release_fall", fall_a, 2'b01);
    tick();
    check("release_level", level_a, 2'b00);

    // Bounce: 3 low, 1 high, 3 low, 1 high, then held low
    raw_a = 2'b10; ticks(3);
    raw_a = 2'b11; tick();
    raw_a = 2'b10; ticks(3);
    raw_a = 2'b11; tick();
    ticks(4);
    check("bounce_level", level_a, 2'b00);
    raw_a = 2'b10;
    ticks(5);
    check("bounce_hold_early", level_a, 2'b00);
    tick();
    check("bounce_hold_rise", rise_a, 2'b01);
    check("bounce_hold_level", level_a, 2'b01);

    // Release channel 0 and press channel 1 on the same edge
    raw_a = 2'b01;
    ticks(5);
    tick();
    check("indep_fall", fall_a, 2'b01);
    check("indep_rise", rise_a, 2'b10);
    check("indep_level", level_a, 2'b10);

    raw_a = 2'b11;
    ticks(8);
    check("idle2_level", level_a, 2'b00);

    // Reset during settling on channel 1
    raw_a = 2'b01;
    ticks(2);
    reset_a = 1'b1;
    ticks(2);
    check("rst_mid_level", level_a, 2'b00);
    check("rst_mid_rise", rise_a, 2'b00);
    reset_a = 1'b0;
    ticks(5);
    check("rst_requal_early", level_a, 2'b00);
    tick();
    check("rst_requal_rise", rise_a, 2'b10);
    check("rst_requal_level", level_a, 2'b10);

    // Active-high polarity on the second instance
    raw_b = 2'b01;
    ticks(5);
    tick();
    check("pol_rise", rise_b, 2'b01);
    check("pol_level", level_b, 2'b01);
    raw_b = 2'b00;
    ticks(5);
    tick();
    check("pol_fall", fall_b, 2'b01);
    check("pol_level_off", level_b, 2'b00);

    // Random pin activity with varied hold times and occasional resets
    for (int i = 0; i < 800; i++) begin
      if (hold_a == 0) begin
        raw_a = 2'($urandom);
        hold_a = int'($urandom_range(1, 9));
      end
      if (hold_b == 0) begin
        raw_b = 2'($urandom);
        hold_b = int'($urandom_range(1, 9));
      end
      hold_a--;
      hold_b--;
      reset_a = ($urandom_range(0, 59) == 0);
      reset_b = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
